cs_thermo_ctrl_avg: RTL and testbench
=====================================

# cs_thermo_ctrl_avg

Parametrised digital controller for the current-source (CS) slice array. It averages 2^AVG_LOG2 ring-oscillator count samples and compares the average against a user voltage window. From that comparison it steps a thermometer-coded slice enable up or down, with saturation, lock detection and a bypass path. It sits between the frequency-divided RO counter and the CS slice enables, and is the generalised successor of the 32-slice, single-sample up/down controller.

## Interface
- N_SLICES, 32: number of CS slices, i.e. the thermometer code width.
- COUNT_W, 8: width of the RO count and of the bounds.
- AVG_LOG2, 2: number of samples averaged per decision is 2^AVG_LOG2; 0 means no averaging.
- STEP, 1: slices turned on or off per decision, 1..N_SLICES.
- INIT_ON, 16: slices on after reset, 0..N_SLICES.
- LOCK_CNT, 4: consecutive in-band decisions needed to assert LOCKED, ≥1.

Ports:
- CLK  in  1  clock; one clock domain.
- RST_N  in  1  reset, asynchronous, active-low.
- COUNTER  in  COUNT_W  RO count, valid while COUNT_DONE is high.
- COUNT_DONE  in  1  count-complete level, synchronous to CLK.
- LOWER_VOLTAGE_BOUND  in  COUNT_W  below this average, turn slices on.
- UPPER_VOLTAGE_BOUND  in  COUNT_W  above this average, turn slices off.
- LOOP_BYPASS  in  1  forces OUT_CODE to BYPASS_CODE.
- BYPASS_CODE  in  N_SLICES  direct slice enables used in bypass.
- OUT_CODE  out  N_SLICES  registered slice enables; bit i is high iff i < ON_COUNT (outside bypass).
- ON_COUNT  out  clog2(N_SLICES+1)  slices currently commanded on.
- UPDATE  out  1  one-cycle pulse for each completed decision.
- AT_MAX  out  1  ON_COUNT == N_SLICES.
- AT_MIN  out  1  ON_COUNT == 0.
- LOCKED  out  1  loop settled inside the window.

## Operation
- **Sampling**
  - Sample strobe is the rising edge of COUNT_DONE: COUNT_DONE=1 and its registered copy =0. Exactly one sample per high pulse, however long the pulse.
  - Each sample adds COUNTER into an accumulator of COUNT_W+AVG_LOG2 bits (cannot overflow) and increments a sample counter.
- **Decision**
  - On the 2^AVG_LOG2-th sample: avg = (acc + COUNTER) >> AVG_LOG2 (truncating). The accumulator and sample counter clear and a decision is raised.
  - Comparisons are unsigned:
    - avg < LOWER: ON_COUNT = min(ON_COUNT+STEP, N_SLICES).
    - avg > UPPER: ON_COUNT = max(ON_COUNT−STEP, 0).
    - Otherwise ON_COUNT holds. The in-band case includes avg equal to either bound.
  - If LOWER > UPPER, every decision holds and counts as out-of-band for lock purposes.
- **Lock**
  - The lock counter increments on each in-band decision, saturating at LOCK_CNT.
  - LOCKED = (lock counter == LOCK_CNT).
  - Any out-of-band decision clears the counter and LOCKED, including one at saturation that produces no change.
- **Flags**
  - UPDATE pulses on every decision, even when ON_COUNT does not change.
  - AT_MAX and AT_MIN track ON_COUNT.
- **Bypass** (LOOP_BYPASS=1)
  - OUT_CODE follows BYPASS_CODE.
  - Accumulator, sample counter and lock counter clear; LOCKED=0.
  - No sampling or decisions take place, and any pending decision is discarded.
  - ON_COUNT is held.
  - Bypass has priority over a simultaneous final sample.
  - On exit, OUT_CODE returns to the thermometer code of ON_COUNT, and averaging restarts from zero samples.
- **Reset values**
  - ON_COUNT=INIT_ON; OUT_CODE = thermometer code of INIT_ON (default 0x0000FFFF).
  - AT_MAX=(INIT_ON==N_SLICES), AT_MIN=(INIT_ON==0).
  - UPDATE=0, LOCKED=0; accumulator, sample and lock counters all 0.
  - Reset mid-window discards all partial samples.

## Timing
- COUNT_DONE rise sampled at clock edge E0 (the edge at which COUNT_DONE=1 and its registered copy =0).
- Final sample captured at edge E; the avg/decision register loads at E.
- OUT_CODE, ON_COUNT, AT_MAX, AT_MIN and LOCKED update at E+1. UPDATE is high during the cycle following E+1.
- Fastest decision rate: one per 2^AVG_LOG2 COUNT_DONE pulses, each pulse needing at least 1 cycle low between highs.
- LOOP_BYPASS and BYPASS_CODE changes reach OUT_CODE at the next edge (1-cycle latency), both on entry and on exit.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
All scenarios use default parameters.
- **Reset:** assert RST_N=0 asynchronously mid-cycle → OUT_CODE=0x0000FFFF, ON_COUNT=16, AT_MAX=0, AT_MIN=0, LOCKED=0, UPDATE=0 immediately.
- **Averaging gate and up-step:** bounds 50/60; three pulses with COUNTER=10 → no UPDATE. Fourth pulse → one cycle later ON_COUNT=17, OUT_CODE=0x0001FFFF, single UPDATE pulse. A COUNT_DONE held high for 20 cycles counts as one sample.
- **Average edge cases:** samples 40,40,80,80 (avg 60 = UPPER) → hold, UPDATE pulses. Samples 40,40,80,84 (avg 61) → ON_COUNT decrements by 1.
- **Saturation:** 20 low-average windows from reset → ON_COUNT=32, OUT_CODE=0xFFFFFFFF, AT_MAX=1; further low windows keep these values and still pulse UPDATE. Mirror test to 0 checks AT_MIN=1 and OUT_CODE=0.
- **Lock:** four consecutive in-band windows → LOCKED rises with the 4th decision. One high-average window → LOCKED=0 and ON_COUNT decrements. LOWER=70, UPPER=60 with in-band data → LOCKED never asserts.
- **Bypass mid-window:** after 2 samples, LOOP_BYPASS=1 with BYPASS_CODE=0xA5A5A5A5 → OUT_CODE=0xA5A5A5A5 next edge, pulses ignored, LOCKED=0. Deassert → OUT_CODE returns to the held thermometer code next edge; exactly 4 fresh samples are then required for the next UPDATE.

Source files
------------

// File: rtl/cs_thermo_ctrl_avg.sv
// cs_thermo_ctrl_avg
//   Averages 2^AVG_LOG2 ring-oscillator count samples and steps a thermometer-coded
//   current-source slice enable up or down against a voltage window. Includes
//   saturation flags, lock detection and a direct bypass path.
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   COUNTER, COUNT_DONE   RO count and its completion level (one sample per rising edge)
//   LOWER/UPPER_VOLTAGE_BOUND  in-band window for the averaged count (inclusive)
//   LOOP_BYPASS, BYPASS_CODE   force OUT_CODE to BYPASS_CODE, freeze the loop
//   OUT_CODE, ON_COUNT    registered slice enables and number of slices on
//   UPDATE                one-cycle pulse per completed decision
//   AT_MAX, AT_MIN, LOCKED     status flags, all registered
module cs_thermo_ctrl_avg #(
    parameter int unsigned N_SLICES = 32,
    parameter int unsigned COUNT_W  = 8,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned STEP     = 1,
    parameter int unsigned INIT_ON  = 16,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [COUNT_W-1:0]            COUNTER,
    input  logic                          COUNT_DONE,
    input  logic [COUNT_W-1:0]            LOWER_VOLTAGE_BOUND,
    input  logic [COUNT_W-1:0]            UPPER_VOLTAGE_BOUND,
    input  logic                          LOOP_BYPASS,
    input  logic [N_SLICES-1:0]           BYPASS_CODE,
    output logic [N_SLICES-1:0]           OUT_CODE,
    output logic [$clog2(N_SLICES+1)-1:0] ON_COUNT,
    output logic                          UPDATE,
    output logic                          AT_MAX,
    output logic                          AT_MIN,
    output logic                          LOCKED
);

    localparam int unsigned CW = $clog2(N_SLICES + 1);
    localparam int unsigned AW = COUNT_W + AVG_LOG2;
    localparam int unsigned SW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned LW = $clog2(LOCK_CNT + 1);

    localparam logic [SW-1:0] LastSample = SW'((32'd1 << AVG_LOG2) - 32'd1);
    localparam logic [CW-1:0] NMax       = CW'(N_SLICES);
    localparam logic [CW-1:0] StepVal    = CW'(STEP);
    localparam logic [CW-1:0] InitOn     = CW'(INIT_ON);
    localparam logic [LW-1:0] LockMax    = LW'(LOCK_CNT);

    function automatic logic [N_SLICES-1:0] therm(input logic [CW-1:0] n);
        logic [N_SLICES-1:0] code;
        for (int unsigned i = 0; i < N_SLICES; i++) begin
            code[i] = (CW'(i) < n);
        end
        return code;
    endfunction

    // Sampling stage state
    logic               done_q;
    logic [AW-1:0]      acc_q, acc_d;
    logic [SW-1:0]      smp_q, smp_d;
    // Decision register, loaded with the final sample
    logic               dec_q, dec_d;
    logic               up_q, up_d, dn_q, dn_d, inb_q, inb_d;
    // Output stage state
    logic [CW-1:0]       on_q, on_d;
    logic [LW-1:0]       lock_q, lock_d;
    logic [N_SLICES-1:0] code_q, code_d;
    logic                upd_q, upd_d, max_q, min_q, locked_q;

    logic               sample, last;
    logic [AW-1:0]      acc_sum;
    logic [COUNT_W-1:0] avg;
    logic               bad_bounds;
    logic [CW:0]        up_sum;

    assign sample     = COUNT_DONE & ~done_q & ~LOOP_BYPASS;
    assign last       = sample && (smp_q == LastSample);
    assign acc_sum    = acc_q + AW'(COUNTER);
    assign avg        = COUNT_W'(acc_sum >> AVG_LOG2);
    // An inverted window never counts as in-band and never moves the code.
    assign bad_bounds = LOWER_VOLTAGE_BOUND > UPPER_VOLTAGE_BOUND;
    assign up_sum     = {1'b0, on_q} + {1'b0, StepVal};

    always_comb begin
        acc_d = acc_q;
        smp_d = smp_q;
        dec_d = 1'b0;
        up_d  = 1'b0;
        dn_d  = 1'b0;
        inb_d = 1'b0;
        if (LOOP_BYPASS) begin
            acc_d = '0;
            smp_d = '0;
        end else if (last) begin
            acc_d = '0;
            smp_d = '0;
            dec_d = 1'b1;
            up_d  = !bad_bounds && (avg < LOWER_VOLTAGE_BOUND);
            dn_d  = !bad_bounds && (avg > UPPER_VOLTAGE_BOUND);
            inb_d = !bad_bounds && !(avg < LOWER_VOLTAGE_BOUND)
                    && !(avg > UPPER_VOLTAGE_BOUND);
        end else if (sample) begin
            acc_d = acc_sum;
            smp_d = smp_q + SW'(1);
        end
    end

    always_comb begin
        on_d   = on_q;
        lock_d = lock_q;
        upd_d  = 1'b0;
        if (LOOP_BYPASS) begin
            // A decision pending from the previous edge is dropped here.
            lock_d = '0;
        end else if (dec_q) begin
            upd_d = 1'b1;
            if (up_q) begin
                on_d = (up_sum > {1'b0, NMax}) ? NMax : up_sum[CW-1:0];
            end else if (dn_q) begin
                on_d = (on_q < StepVal) ? '0 : on_q - StepVal;
            end
            if (inb_q) begin
                lock_d = (lock_q == LockMax) ? lock_q : lock_q + LW'(1);
            end else begin
                lock_d = '0;
            end
        end
        code_d = LOOP_BYPASS ? BYPASS_CODE : therm(on_d);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            done_q   <= 1'b0;
            acc_q    <= '0;
            smp_q    <= '0;
            dec_q    <= 1'b0;
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
            inb_q    <= 1'b0;
            on_q     <= InitOn;
            lock_q   <= '0;
            code_q   <= therm(InitOn);
            upd_q    <= 1'b0;
            max_q    <= (InitOn == NMax);
            min_q    <= (InitOn == '0);
            locked_q <= 1'b0;
        end else begin
            done_q   <= COUNT_DONE;
            acc_q    <= acc_d;
            smp_q    <= smp_d;
            dec_q    <= dec_d;
            up_q     <= up_d;
            dn_q     <= dn_d;
            inb_q    <= inb_d;
            on_q     <= on_d;
            lock_q   <= lock_d;
            code_q   <= code_d;
            upd_q    <= upd_d;
            max_q    <= (on_d == NMax);
            min_q    <= (on_d == '0);
            locked_q <= (lock_d == LockMax);
        end
    end

    assign OUT_CODE = code_q;
    assign ON_COUNT = on_q;
    assign UPDATE   = upd_q;
    assign AT_MAX   = max_q;
    assign AT_MIN   = min_q;
    assign LOCKED   = locked_q;

endmodule

// File: tb/tb_cs_thermo_ctrl_avg.sv
module tb_cs_thermo_ctrl_avg;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic [7:0]  COUNTER = '0;
    logic        COUNT_DONE = 1'b0;
    logic [7:0]  lo = 8'd50;
    logic [7:0]  hi = 8'd60;
    logic        byp = 1'b0;
    logic [31:0] bcode = '0;
    logic [31:0] OUT_CODE;
    logic [5:0]  ON_COUNT;
    logic        UPDATE, AT_MAX, AT_MIN, LOCKED;

    cs_thermo_ctrl_avg dut (
        .CLK                (CLK),
        .RST_N              (RST_N),
        .COUNTER            (COUNTER),
        .COUNT_DONE         (COUNT_DONE),
        .LOWER_VOLTAGE_BOUND(lo),
        .UPPER_VOLTAGE_BOUND(hi),
        .LOOP_BYPASS        (byp),
        .BYPASS_CODE        (bcode),
        .OUT_CODE           (OUT_CODE),
        .ON_COUNT           (ON_COUNT),
        .UPDATE             (UPDATE),
        .AT_MAX             (AT_MAX),
        .AT_MIN             (AT_MIN),
        .LOCKED             (LOCKED)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [5:0]  on;
        logic [31:0] code;
        logic        lk;
        logic        mx;
        logic        mn;
    } exp_t;

    exp_t sb[$];
    exp_t e, obs;
    int   total = 0;
    int   bad = 0;
    int   upd_pulses = 0;
    int   m_on = 16;
    int   m_lock = 0;
    int   n0;
    bit   ok;

    // Advance to the next falling edge and count UPDATE pulses seen there.
    task automatic tick();
        @(negedge CLK);
        if (UPDATE === 1'b1) upd_pulses++;
    endtask

    task automatic pulse(input int v, input int hold);
        COUNTER = 8'(v);
        COUNT_DONE = 1'b1;
        repeat (hold) tick();
        COUNT_DONE = 1'b0;
        tick();
    endtask

    function automatic exp_t model_exp();
        exp_t r;
        logic [63:0] t;
        t = (64'd1 << m_on) - 64'd1;
        r.on = 6'(m_on);
        r.code = t[31:0];
        r.lk = (m_lock == 4);
        r.mx = (m_on == 32);
        r.mn = (m_on == 0);
        return r;
    endfunction

    task automatic model_reset();
        m_on = 16;
        m_lock = 0;
        sb.delete();
    endtask

    task automatic push_window(input int s0, input int s1, input int s2, input int s3);
        int avg;
        avg = (s0 + s1 + s2 + s3) >> 2;
        if (lo > hi) begin
            m_lock = 0;
        end else if (avg < int'(lo)) begin
            m_on = (m_on + 1 > 32) ? 32 : m_on + 1;
            m_lock = 0;
        end else if (avg > int'(hi)) begin
            m_on = (m_on - 1 < 0) ? 0 : m_on - 1;
            m_lock = 0;
        end else begin
            m_lock = (m_lock + 1 > 4) ? 4 : m_lock + 1;
        end
        sb.push_back(model_exp());
    endtask

    task automatic run_window(input int s0, input int s1, input int s2, input int s3);
        push_window(s0, s1, s2, s3);
        pulse(s0, 1);
        pulse(s1, 1);
        pulse(s2, 1);
        pulse(s3, 1);
    endtask

    task automatic wait_upd(input int base, output bit got);
        for (int i = 0; i < 30 && upd_pulses == base; i++) tick();
        got = (upd_pulses != base);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_reset();
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        model_reset();
        e = model_exp();
        obs = {ON_COUNT, OUT_CODE, LOCKED, AT_MAX, AT_MIN};
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL reset_state: got %h want %h", obs, e);
        end
        total++;
        if (UPDATE !== 1'b0) begin
            bad++;
            $display("FAIL reset_update: got %b want 0", UPDATE);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_upstep();
        lo = 8'd50;
        hi = 8'd60;
        n0 = upd_pulses;
        push_window(10, 10, 10, 10);
        repeat (3) pulse(10, 1);
        total++;
        if (upd_pulses != n0 || ON_COUNT !== 6'd16) begin
            bad++;
            $display("FAIL upstep_gate: got upd=%0d on=%0d want upd=0 on=16",
                     upd_pulses - n0, ON_COUNT);
        end
        pulse(10, 1);
        wait_upd(n0, ok);
        e = sb.pop_front();
        obs = {ON_COUNT, OUT_CODE, LOCKED, AT_MAX, AT_MIN};
        total++;
        if (!ok || obs !== e) begin
            bad++;
            $display("FAIL upstep_decision: got %h upd=%b want %h upd=1", obs, ok, e);
        end
        tick();
        tick();
        total++;
        if (upd_pulses != n0 + 1) begin
            bad++;
            $display("FAIL upstep_single_pulse: got %0d want 1", upd_pulses - n0);
        end
        // A long COUNT_DONE level is one sample only.
        n0 = upd_pulses;
        push_window(10, 10, 10, 10);
        pulse(10, 20);
        pulse(10, 1);
        pulse(10, 1);
        total++;
        if (upd_pulses != n0) begin
            bad++;
            $display("FAIL long_pulse_gate: got %0d updates want 0", upd_pulses - n0);
        end
        pulse(10, 1);
        wait_upd(n0, ok);
        e = sb.pop_front();
        obs = {ON_COUNT, OUT_CODE, LOCKED, AT_MAX, AT_MIN};
        total++;
        if (!ok || obs !== e) begin
            bad++;
            $display("FAIL long_pulse_decision: got %h upd=%b want %h upd=1", obs, ok, e);
        end
    endtask

    task automatic test_avg_edges();
        lo = 8'd50;
        hi = 8'd60;
        n0 = upd_pulses;
        run_window(40, 40, 80, 80);
        wait_upd(n0, ok);
        e = sb.pop_front();
        obs = {ON_COUNT, OUT_CODE, LOCKED, AT_MAX, AT_MIN};
        total++;
        if (!ok || obs !== e) begin
            bad++;
            $display("FAIL avg_eq_upper: got %h upd=%b want %h upd=1", obs, ok, e);
        end
        n0 = upd_pulses;
        run_window(40, 40, 80, 84);
        wait_upd(n0, ok);
        e = sb.pop_front();
        obs = {ON_COUNT, OUT_CODE, LOCKED, AT_MAX, AT_MIN};
        total++;
        if (!ok || obs !== e) begin
            bad++;
            $display("FAIL avg_above_upper: got %h upd=%b want %h upd=1", obs, ok, e);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        lo = 8'd50;
        hi = 8'd60;
        for (int w = 0; w < 22; w++) begin
            n0 = upd_pulses;
            run_window(10, 10, 10, 10);
            wait_upd(n0, ok);
            e = sb.pop_front();
            obs = {ON_COUNT, OUT_CODE, LOCKED, AT_MAX, AT_MIN};
            total++;
            if (!ok || obs !== e) begin
                bad++;
                $display("FAIL sat_max w%0d: got %h upd=%b want %h upd=1", w, obs, ok, e);
            end
        end
        for (int w = 0; w < 34; w++) begin
            n0 = upd_pulses;
            run_window(100, 100, 100, 100);
            wait_upd(n0, ok);
            e = sb.pop_front();
            obs = {ON_COUNT, OUT_CODE, LOCKED, AT_MAX, AT_MIN};
            total++;
            if (!ok || obs !== e) begin
                bad++;
                $display("FAIL sat_min w%0d: got %h upd=%b want %h upd=1", w, obs, ok, e);
            end
        end
    endtask

    task automatic test_lock();
        do_reset();
        lo = 8'd50;
        hi = 8'd60;
        for (int w = 0; w < 4; w++) begin
            n0 = upd_pulses;
            run_window(55, 55, 55, 55);
            wait_upd(n0, ok);
            e = sb.pop_front();
            obs = {ON_COUNT, OUT_CODE, LOCKED, AT_MAX, AT_MIN};
            total++;
            if (!ok || obs !== e) begin
                bad++;
                $display("FAIL lock_build w%0d: got %h upd=%b want %h upd=1", w, obs, ok, e);
            end
        end
        n0 = upd_pulses;
        run_window(100, 100, 100, 100);
        wait_upd(n0, ok);
        e = sb.pop_front();
        obs = {ON_COUNT, OUT_CODE, LOCKED, AT_MAX, AT_MIN};
        total++;
        if (!ok || obs !== e) begin
            bad++;
            $display("FAIL lock_break: got %h upd=%b want %h upd=1", obs, ok, e);
        end
        lo = 8'd70;
        hi = 8'd60;
        for (int w = 0; w < 5; w++) begin
            n0 = upd_pulses;
            run_window(65, 65, 65, 65);
            wait_upd(n0, ok);
            e = sb.pop_front();
            obs = {ON_COUNT, OUT_CODE, LOCKED, AT_MAX, AT_MIN};
            total++;
            if (!ok || obs !== e) begin
                bad++;
                $display("FAIL lock_inverted w%0d: got %h upd=%b want %h upd=1", w, obs, ok, e);
            end
        end
    endtask

    task automatic test_bypass();
        do_reset();
        lo = 8'd50;
        hi = 8'd60;
        for (int w = 0; w < 4; w++) begin
            n0 = upd_pulses;
            run_window(55, 55, 55, 55);
            wait_upd(n0, ok);
            e = sb.pop_front();
            obs = {ON_COUNT, OUT_CODE, LOCKED, AT_MAX, AT_MIN};
            total++;
            if (!ok || obs !== e) begin
                bad++;
                $display("FAIL bypass_prelock w%0d: got %h upd=%b want %h upd=1", w, obs, ok, e);
            end
        end
        pulse(10, 1);
        pulse(10, 1);
        byp = 1'b1;
        bcode = 32'hA5A5_A5A5;
        m_lock = 0;
        total++;
        if (OUT_CODE !== 32'h0000_FFFF) begin
            bad++;
            $display("FAIL bypass_entry_latency: got %h want 0000ffff", OUT_CODE);
        end
        tick();
        total++;
        if (OUT_CODE !== 32'hA5A5_A5A5 || LOCKED !== 1'b0 || ON_COUNT !== 6'd16) begin
            bad++;
            $display("FAIL bypass_entry: got code=%h lk=%b on=%0d want a5a5a5a5 0 16",
                     OUT_CODE, LOCKED, ON_COUNT);
        end
        n0 = upd_pulses;
        repeat (4) pulse(10, 1);
        tick();
        tick();
        total++;
        if (upd_pulses != n0 || ON_COUNT !== 6'd16 || OUT_CODE !== 32'hA5A5_A5A5) begin
            bad++;
            $display("FAIL bypass_ignore: got upd=%0d on=%0d code=%h want 0 16 a5a5a5a5",
                     upd_pulses - n0, ON_COUNT, OUT_CODE);
        end
        bcode = 32'h1234_5678;
        tick();
        total++;
        if (OUT_CODE !== 32'h1234_5678) begin
            bad++;
            $display("FAIL bypass_follow: got %h want 12345678", OUT_CODE);
        end
        byp = 1'b0;
        tick();
        total++;
        if (OUT_CODE !== 32'h0000_FFFF || LOCKED !== 1'b0) begin
            bad++;
            $display("FAIL bypass_exit: got code=%h lk=%b want 0000ffff 0", OUT_CODE, LOCKED);
        end
        n0 = upd_pulses;
        push_window(10, 10, 10, 10);
        repeat (3) pulse(10, 1);
        total++;
        if (upd_pulses != n0) begin
            bad++;
            $display("FAIL bypass_restart_gate: got %0d updates want 0", upd_pulses - n0);
        end
        pulse(10, 1);
        wait_upd(n0, ok);
        e = sb.pop_front();
        obs = {ON_COUNT, OUT_CODE, LOCKED, AT_MAX, AT_MIN};
        total++;
        if (!ok || obs !== e) begin
            bad++;
            $display("FAIL bypass_restart: got %h upd=%b want %h upd=1", obs, ok, e);
        end
    endtask

    task automatic test_reset_midwindow();
        lo = 8'd50;
        hi = 8'd60;
        pulse(10, 1);
        pulse(10, 1);
        #2 RST_N = 1'b0;
        #1;
        model_reset();
        e = model_exp();
        obs = {ON_COUNT, OUT_CODE, LOCKED, AT_MAX, AT_MIN};
        total++;
        if (obs !== e || UPDATE !== 1'b0) begin
            bad++;
            $display("FAIL midwindow_reset: got %h upd=%b want %h upd=0", obs, UPDATE, e);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        n0 = upd_pulses;
        push_window(10, 10, 10, 10);
        repeat (3) pulse(10, 1);
        total++;
        if (upd_pulses != n0) begin
            bad++;
            $display("FAIL midwindow_gate: got %0d updates want 0", upd_pulses - n0);
        end
        pulse(10, 1);
        wait_upd(n0, ok);
        e = sb.pop_front();
        obs = {ON_COUNT, OUT_CODE, LOCKED, AT_MAX, AT_MIN};
        total++;
        if (!ok || obs !== e) begin
            bad++;
            $display("FAIL midwindow_decision: got %h upd=%b want %h upd=1", obs, ok, e);
        end
    endtask

    initial begin
        test_reset();
        test_upstep();
        test_avg_edges();
        test_saturation();
        test_lock();
        test_bypass();
        test_reset_midwindow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
